// File: rtl/full_adder_nbit_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_nbit_pkg
//   Shared constants for the N-bit ripple-carry adder.
//   FA_DEFAULT_WIDTH : default operand/sum width.
//   FA_MAX_WIDTH     : widest supported operand/sum width.
// -----------------------------------------------------------------------------
package full_adder_nbit_pkg;

  localparam int FA_DEFAULT_WIDTH = 4;
  localparam int FA_MAX_WIDTH     = 64;

endpackage : full_adder_nbit_pkg

// File: rtl/full_adder_nbit_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single-bit combinational full-adder cell; the leaf of the ripple chain.
//   Ports:
//     a, b  : input  addend bits
//     cin   : input  carry in
//     s     : output sum bit
//     cout  : output carry out (majority of a, b, cin)
// -----------------------------------------------------------------------------
module full_adder
  import full_adder_nbit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/full_adder_nbit.sv
// -----------------------------------------------------------------------------
// full_adder_nbit
//   Parameterised WIDTH-bit ripple-carry adder (a + b + cin) built from
//   full_adder cells, with a one-cycle registered result stage.
//
//   Parameter:
//     WIDTH   : operand and sum width, 1..FA_MAX_WIDTH (default 4)
//   Ports:
//     clk     : rising-edge clock
//     rst     : asynchronous active-high reset
//     in_vld  : operands valid this cycle
//     a, b    : addends (WIDTH bits)
//     cin     : carry in
//     out_vld : s/cout (and ovf) hold a result captured on the last edge
//     s       : registered sum
//     cout    : registered carry-out of the MSB
//     ovf     : registered two's-complement overflow
//               (only when FULL_ADDER_NBIT_OVF_EN is defined)
//
//   Optional feature macro: FULL_ADDER_NBIT_OVF_EN
//
//   Handshake: in_vld is a pure valid with no ready; every cycle with
//   in_vld = 1 is accepted and produces out_vld = 1 on the following cycle.
//   With in_vld = 0 the result registers hold and out_vld drops to 0.
// -----------------------------------------------------------------------------
module full_adder_nbit
  import full_adder_nbit_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_vld,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef FULL_ADDER_NBIT_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Carry vector: c[0] is the carry-in, c[WIDTH] the carry-out of the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_w;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum_w[i]),
      .cout (c[i+1])
    );
  end

  // Result registers
  logic [WIDTH-1:0] s_q,    s_d;
  logic             cout_q, cout_d;
  logic             vld_q,  vld_d;

  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    vld_d  = in_vld;
    if (in_vld) begin
      s_d    = sum_w;
      cout_d = c[WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
    end
  end

  assign s       = s_q;
  assign cout    = cout_q;
  assign out_vld = vld_q;

`ifdef FULL_ADDER_NBIT_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  // For WIDTH = 1 the carry into the sign bit is cin itself.
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (in_vld) begin
      ovf_d = c[WIDTH] ^ c[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule : full_adder_nbit

// File: tb/tb_full_adder_nbit.sv
// -----------------------------------------------------------------------------
// tb_full_adder_nbit
//   Self-checking bench for full_adder_nbit: a WIDTH = 10 instance for the
//   main scenarios and a WIDTH = 1 instance for the exhaustive cell check.
//   Expected values come from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_full_adder_nbit;

  localparam int W  = 10;
  localparam int W1 = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH = 10 instance
  logic          in_vld;
  logic [W-1:0]  a, b;
  logic          cin;
  logic          out_vld;
  logic [W-1:0]  s;
  logic          cout;

  // WIDTH = 1 instance
  logic          in_vld1;
  logic [W1-1:0] a1, b1;
  logic          cin1;
  logic          out_vld1;
  logic [W1-1:0] s1;
  logic          cout1;

`ifdef FULL_ADDER_NBIT_OVF_EN
  logic ovf;
  logic ovf1;
`endif

  full_adder_nbit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .out_vld (out_vld),
    .s       (s),
    .cout    (cout)
`ifdef FULL_ADDER_NBIT_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  full_adder_nbit #(.WIDTH(W1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld1),
    .a       (a1),
    .b       (b1),
    .cin     (cin1),
    .out_vld (out_vld1),
    .s       (s1),
    .cout    (cout1)
`ifdef FULL_ADDER_NBIT_OVF_EN
    ,
    .ovf     (ovf1)
`endif
  );

  // scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  // reference model state for the WIDTH = 10 instance
  logic [W-1:0] m_s;
  logic         m_cout;
  logic         m_ovf;
  logic         m_vld;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Unsigned exact sum: returns {cout, s} as an integer in [0, 2^(w+1)).
  function automatic longint ref_sum(input int w, input longint x, input longint y, input longint c);
    return x + y + c;
  endfunction

  // Signed overflow: interpret x, y as w-bit two's-complement values and
  // flag when x + y + c falls outside the representable signed range.
  function automatic logic ref_ovf(input int w, input longint x, input longint y, input longint c);
    longint half, sx, sy, r;
    half = longint'(1) << (w - 1);
    sx = (x >= half) ? x - 2 * half : x;
    sy = (y >= half) ? y - 2 * half : y;
    r  = sx + sy + c;
    return (r > half - 1) || (r < -half);
  endfunction

  task automatic check_main(input string tag);
    check({tag, "_vld"},  64'(out_vld), 64'(m_vld));
    check({tag, "_s"},    64'(s),       64'(m_s));
    check({tag, "_cout"}, 64'(cout),    64'(m_cout));
`ifdef FULL_ADDER_NBIT_OVF_EN
    check({tag, "_ovf"},  64'(ovf),     64'(m_ovf));
`endif
  endtask

  // Drive one operand set, clock it in, update the model, check outputs.
  task automatic step(input string tag, input logic v, input int aa, input int bb, input int cc);
    longint r;
    in_vld = v;
    a      = W'(aa);
    b      = W'(bb);
    cin    = cc[0];
    @(posedge clk);
    #1;
    if (v) begin
      r      = ref_sum(W, longint'(aa), longint'(bb), longint'(cc));
      m_s    = W'(r % (longint'(1) << W));
      m_cout = (r >= (longint'(1) << W));
      m_ovf  = ref_ovf(W, longint'(aa), longint'(bb), longint'(cc));
      m_vld  = 1'b1;
    end else begin
      m_vld  = 1'b0;
    end
    check_main(tag);
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_vld = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_vld1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    m_s = '0; m_cout = 1'b0; m_ovf = 1'b0; m_vld = 1'b0;

    // power-on reset state
    #1;
    check_main("por");
    check("por_vld1", 64'(out_vld1), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // load a nonzero result so the reset check below is meaningful
    step("pre", 1'b1, 'h0AB, 'h011, 1);
    check("pre_s_const", 64'(s), 64'h0BD);

    // 1. asynchronous reset mid-cycle with a valid operand presented
    @(negedge clk);
    in_vld = 1'b1; a = W'('h155); b = '0; cin = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    m_s = '0; m_cout = 1'b0; m_ovf = 1'b0; m_vld = 1'b0;
    check_main("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_main("rst_hold");
    @(negedge clk);
    rst = 1'b0;

    // first capture after release
    step("rst_first", 1'b1, 'h155, 'h000, 0);
    check("rst_first_s_const", 64'(s), 64'h155);

    // 2. carry wrap: all-ones + 0 + 1
    step("wrap", 1'b1, 'h3FF, 'h000, 1);
    check("wrap_s_const",    64'(s),    64'h000);
    check("wrap_cout_const", 64'(cout), 64'd1);

    // zero + zero + zero
    step("zero", 1'b1, 'h000, 'h000, 0);
    check("zero_cout_const", 64'(cout), 64'd0);

    // 3. plain add then hold
    step("plain", 1'b1, 'h0C8, 'h12C, 0);
    check("plain_s_const", 64'(s), 64'h1F4);
    step("hold", 1'b0, 'h3A5, 'h2C3, 1);
    check("hold_s_const", 64'(s), 64'h1F4);
    step("hold2", 1'b0, 'h111, 'h222, 0);

    // 4. ten back-to-back random operand sets
    for (int i = 0; i < 10; i++) begin
      step("b2b", 1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1));
    end

    // random mix of valid and idle cycles
    for (int i = 0; i < 30; i++) begin
      step("mix", 1'($urandom_range(0, 1)), $urandom_range(0, 1023),
           $urandom_range(0, 1023), $urandom_range(0, 1));
    end

`ifdef FULL_ADDER_NBIT_OVF_EN
    // 5. signed overflow
    step("ovf_pos", 1'b1, 'h1FF, 'h001, 0);
    check("ovf_pos_const", 64'(ovf), 64'd1);
    step("ovf_neg", 1'b1, 'h200, 'h200, 0);
    check("ovf_neg_const", 64'(ovf), 64'd1);
    step("ovf_none", 1'b1, 'h001, 'h3FF, 0);
    check("ovf_none_const", 64'(ovf), 64'd0);
`endif

    // 6. WIDTH = 1 exhaustive
    in_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      longint r1;
      v = 3'(i);
      in_vld1 = 1'b1;
      a1 = v[2]; b1 = v[1]; cin1 = v[0];
      @(posedge clk);
      #1;
      r1 = ref_sum(1, longint'(v[2]), longint'(v[1]), longint'(v[0]));
      check("w1_sum", 64'({cout1, s1}), 64'(r1));
      check("w1_vld", 64'(out_vld1), 64'd1);
`ifdef FULL_ADDER_NBIT_OVF_EN
      check("w1_ovf", 64'(ovf1), 64'(ref_ovf(1, longint'(v[2]), longint'(v[1]), longint'(v[0]))));
`endif
    end
    in_vld1 = 1'b0;
    @(posedge clk);
    #1;
    check("w1_idle_vld", 64'(out_vld1), 64'd0);
    check("w1_idle_hold", 64'({cout1, s1}), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_full_adder_nbit
